// File: rtl/updi_pkg.sv
// Shared UPDI types and constants.
//   updi_instruction      instruction codes understood by updi_interface
//   UPDI_CS_*             control/status register addresses used by the poller
//   updi_poll_err_t       poller completion codes
//   updi_cs_poller_state  poller FSM states
package updi_pkg;

    typedef enum logic [3:0] {
        UPDI_LDS    = 4'h0,
        UPDI_STS    = 4'h1,
        UPDI_LD     = 4'h2,
        UPDI_ST     = 4'h3,
        UPDI_LDCS   = 4'h4,
        UPDI_STCS   = 4'h5,
        UPDI_REPEAT = 4'h6,
        UPDI_KEY    = 4'h7
    } updi_instruction;

    localparam logic [3:0] UPDI_CS_STATUSA        = 4'h0;
    localparam logic [3:0] UPDI_CS_ASI_SYS_STATUS = 4'hB;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_EXHAUSTED = 2'd1,
        ERR_LINK      = 2'd2
    } updi_poll_err_t;

    typedef enum logic [3:0] {
        StIdle,
        StFlush,
        StIssue,
        StWaitRx,
        StPop,
        StCheck,
        StGap,
        StResync,
        StRsWait,
        StDone
    } updi_cs_poller_state;

endpackage

// File: rtl/updi_poll_timer.sv
// Loadable down-counter shared by the poll gap and the rx timeout.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load 'value' this cycle (overrides counting)
//   value       reload value
//   expired     high while the count is zero
module updi_poll_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] value,
    output logic             expired
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/updi_cs_poller.sv
// Polls a UPDI control/status register with LDCS until a masked compare holds, the poll budget is
// spent, or the link fails; a stalled link is recovered with a double break.
//   start/cs_addr/mask/expect_val/mode   request, sampled only when idle
//   busy/done/pass/err_code              status; pass/err_code are valid with done and then held
//   last_value/poll_count                last byte read and LDCS count of this request
//   instr_* / interface_*                handshake with updi_interface
//   rx_fifo_*                            rx_out FIFO read side (data valid the cycle after rd_en)
//   double_break_*                       handshake with the double-break generator
module updi_cs_poller
    import updi_pkg::*;
#(
    parameter int unsigned DATA_ADDR_BITS  = 6,
    parameter int unsigned MAX_POLLS       = 255,
    parameter int unsigned POLL_GAP_CLKS   = 1000,
    parameter int unsigned RX_TIMEOUT_CLKS = 20000,
    parameter int unsigned MAX_RESYNC      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                cs_addr,
    input  logic [7:0]                mask,
    input  logic [7:0]                expect_val,
    input  logic                      mode,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [1:0]                err_code,
    output logic [7:0]                last_value,
    output logic [7:0]                poll_count,
    output logic                      instr_converter_en,
    output updi_instruction           instruction,
    output logic [3:0]                instr_cs_addr,
    output logic                      interface_tx_start,
    input  logic                      interface_tx_ready,
    output logic                      interface_rx_start,
    output logic [DATA_ADDR_BITS-1:0] interface_rx_n_bytes,
    input  logic                      interface_rx_done,
    input  logic [7:0]                rx_fifo_data,
    output logic                      rx_fifo_rd_en,
    input  logic                      rx_fifo_empty,
    output logic                      double_break_start,
    input  logic                      double_break_done
);

    localparam int unsigned TimerMax =
        (POLL_GAP_CLKS > RX_TIMEOUT_CLKS) ? POLL_GAP_CLKS : RX_TIMEOUT_CLKS;
    localparam int unsigned TimerW = $clog2(TimerMax + 1);
    localparam logic [7:0]  MaxPollsB  = 8'(MAX_POLLS);
    localparam logic [7:0]  MaxResyncB = 8'(MAX_RESYNC);

    updi_cs_poller_state state_q, state_d;
    updi_poll_err_t      err_q, err_d;
    logic [3:0]          cs_addr_q, cs_addr_d;
    logic [7:0]          mask_q, mask_d, expect_q, expect_d;
    logic                mode_q, mode_d, pass_q, pass_d;
    logic [7:0]          last_q, last_d, poll_q, poll_d, resync_q, resync_d;

    logic              timer_load, timer_expired, cond_met, issue_fire;
    logic [TimerW-1:0] timer_value;

    updi_poll_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    assign issue_fire = (state_q == StIssue) && interface_tx_ready;
    assign cond_met   = mode_q ? ((rx_fifo_data & mask_q) != (expect_q & mask_q))
                               : ((rx_fifo_data & mask_q) == (expect_q & mask_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            err_q     <= ERR_OK;
            cs_addr_q <= '0;
            mask_q    <= '0;
            expect_q  <= '0;
            mode_q    <= 1'b0;
            pass_q    <= 1'b0;
            last_q    <= '0;
            poll_q    <= '0;
            resync_q  <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            cs_addr_q <= cs_addr_d;
            mask_q    <= mask_d;
            expect_q  <= expect_d;
            mode_q    <= mode_d;
            pass_q    <= pass_d;
            last_q    <= last_d;
            poll_q    <= poll_d;
            resync_q  <= resync_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        cs_addr_d   = cs_addr_q;
        mask_d      = mask_q;
        expect_d    = expect_q;
        mode_d      = mode_q;
        pass_d      = pass_q;
        last_d      = last_q;
        poll_d      = poll_q;
        resync_d    = resync_q;
        timer_load  = 1'b0;
        timer_value = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cs_addr_d = cs_addr;
                    mask_d    = mask;
                    expect_d  = expect_val;
                    mode_d    = mode;
                    pass_d    = 1'b0;
                    err_d     = ERR_OK;
                    last_d    = '0;
                    poll_d    = '0;
                    resync_d  = '0;
                    state_d   = StFlush;
                end
            end
            StFlush: begin
                if (rx_fifo_empty) state_d = StIssue;
            end
            StIssue: begin
                if (interface_tx_ready) begin
                    timer_load  = 1'b1;
                    timer_value = TimerW'(RX_TIMEOUT_CLKS);
                    if (poll_q != 8'hFF) poll_d = poll_q + 8'd1;
                    state_d = StWaitRx;
                end
            end
            StWaitRx: begin
                // rx_done takes priority over a coincident timeout
                if (interface_rx_done) begin
                    state_d = StPop;
                end else if (timer_expired) begin
                    state_d = StResync;
                end
            end
            StPop: begin
                if (!rx_fifo_empty) begin
                    state_d = StCheck;
                end else if (timer_expired) begin
                    state_d = StResync;
                end
            end
            StCheck: begin
                last_d = rx_fifo_data;
                if (cond_met) begin
                    pass_d  = 1'b1;
                    err_d   = ERR_OK;
                    state_d = StDone;
                end else if (poll_q >= MaxPollsB) begin
                    err_d   = ERR_EXHAUSTED;
                    state_d = StDone;
                end else begin
                    timer_load  = 1'b1;
                    timer_value = TimerW'(POLL_GAP_CLKS);
                    state_d     = StGap;
                end
            end
            StGap: begin
                if (timer_expired) state_d = StIssue;
            end
            StResync: begin
                if (resync_q == MaxResyncB) begin
                    err_d   = ERR_LINK;
                    state_d = StDone;
                end else begin
                    if (resync_q != 8'hFF) resync_d = resync_q + 8'd1;
                    state_d = StRsWait;
                end
            end
            StRsWait: begin
                if (double_break_done && interface_tx_ready) state_d = StFlush;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy               = (state_q != StIdle) && (state_q != StDone);
        done               = (state_q == StDone);
        instr_converter_en = issue_fire;
        interface_tx_start = issue_fire;
        interface_rx_start = issue_fire;
        rx_fifo_rd_en      = ((state_q == StFlush) || (state_q == StPop)) && !rx_fifo_empty;
        double_break_start = (state_q == StResync) && (resync_q != MaxResyncB);
    end

    assign instruction          = UPDI_LDCS;
    assign interface_rx_n_bytes = DATA_ADDR_BITS'(1);
    assign instr_cs_addr        = cs_addr_q;
    assign pass                 = pass_q;
    assign err_code             = err_q;
    assign last_value           = last_q;
    assign poll_count           = poll_q;

endmodule

// File: tb/tb_updi_cs_poller.sv
module tb_updi_cs_poller;
    import updi_pkg::*;

    localparam int unsigned MaxPolls  = 4;
    localparam int unsigned GapClks   = 20;
    localparam int unsigned RxTimeout = 60;
    localparam int unsigned MaxResync = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            start = 1'b0;
    logic [3:0]      cs_addr = '0;
    logic [7:0]      mask = '0, expect_val = '0;
    logic            mode = 1'b0;
    logic            busy, done, pass;
    logic [1:0]      err_code;
    logic [7:0]      last_value, poll_count;
    logic            instr_converter_en, interface_tx_start, interface_rx_start;
    updi_instruction instruction;
    logic [3:0]      instr_cs_addr;
    logic [5:0]      interface_rx_n_bytes;
    logic            interface_tx_ready, interface_rx_done;
    logic [7:0]      rx_fifo_data;
    logic            rx_fifo_rd_en, rx_fifo_empty;
    logic            double_break_start, double_break_done;

    updi_cs_poller #(
        .DATA_ADDR_BITS  (6),
        .MAX_POLLS       (MaxPolls),
        .POLL_GAP_CLKS   (GapClks),
        .RX_TIMEOUT_CLKS (RxTimeout),
        .MAX_RESYNC      (MaxResync)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .cs_addr              (cs_addr),
        .mask                 (mask),
        .expect_val           (expect_val),
        .mode                 (mode),
        .busy                 (busy),
        .done                 (done),
        .pass                 (pass),
        .err_code             (err_code),
        .last_value           (last_value),
        .poll_count           (poll_count),
        .instr_converter_en   (instr_converter_en),
        .instruction          (instruction),
        .instr_cs_addr        (instr_cs_addr),
        .interface_tx_start   (interface_tx_start),
        .interface_tx_ready   (interface_tx_ready),
        .interface_rx_start   (interface_rx_start),
        .interface_rx_n_bytes (interface_rx_n_bytes),
        .interface_rx_done    (interface_rx_done),
        .rx_fifo_data         (rx_fifo_data),
        .rx_fifo_rd_en        (rx_fifo_rd_en),
        .rx_fifo_empty        (rx_fifo_empty),
        .double_break_start   (double_break_start),
        .double_break_done    (double_break_done)
    );

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    always @(posedge clk) cycle++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // ---------------- link / FIFO / double-break model ----------------
    logic [7:0] resp_arr[8];
    int         resp_len = 1;
    bit         link_alive = 1'b1;
    logic [7:0] stale_bytes[16];
    int         stale_total = 0;
    int         stale_taken = 0;

    logic [7:0] fifo[$];
    int         resp_idx = 0;
    int         xfer_cnt = 0, db_cnt = 0;
    int         tx_count = 0, db_count = 0, pop_count = 0;
    int         tx_cycles[$];

    function automatic logic [7:0] resp_byte(input int idx);
        return (idx < resp_len) ? resp_arr[idx] : resp_arr[resp_len-1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] b;
        if (!rst_n) begin
            fifo.delete();
            xfer_cnt = 0;
            db_cnt   = 0;
            rx_fifo_empty      <= 1'b1;
            interface_tx_ready <= 1'b1;
            interface_rx_done  <= 1'b0;
            double_break_done  <= 1'b0;
            rx_fifo_data       <= '0;
        end else begin
            interface_rx_done <= 1'b0;
            double_break_done <= 1'b0;
            if (start && !busy) resp_idx = 0;
            if (stale_taken < stale_total) begin
                fifo.push_back(stale_bytes[stale_taken]);
                stale_taken++;
            end
            if (rx_fifo_rd_en && fifo.size() > 0) begin
                b = fifo.pop_front();
                rx_fifo_data <= b;
                pop_count++;
            end
            if (interface_tx_start) begin
                tx_count++;
                tx_cycles.push_back(cycle);
                interface_tx_ready <= 1'b0;
                xfer_cnt = $urandom_range(4, 12);
            end else if (xfer_cnt > 0) begin
                xfer_cnt--;
                if (xfer_cnt == 0) begin
                    interface_tx_ready <= 1'b1;
                    if (link_alive) begin
                        fifo.push_back(resp_byte(resp_idx));
                        resp_idx++;
                        interface_rx_done <= 1'b1;
                    end
                end
            end
            if (double_break_start) begin
                db_count++;
                db_cnt = $urandom_range(5, 15);
            end else if (db_cnt > 0) begin
                db_cnt--;
                if (db_cnt == 0) double_break_done <= 1'b1;
            end
            rx_fifo_empty <= (fifo.size() == 0);
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit         pass;
        int         err;
        logic [7:0] last;
        int         polls;
        int         dbs;
        int         pops;
        logic [3:0] addr;
        int         tx_base;
        int         db_base;
        int         pop_base;
    } exp_t;

    exp_t exp_q[$];

    // Outcome of a request from the polling rules alone.
    function automatic exp_t predict(input logic [7:0] m, input logic [7:0] e, input logic md,
                                     input int stale_n);
        exp_t x;
        x.pass = 1'b0; x.err = 0; x.last = 8'h00; x.polls = 0; x.dbs = 0; x.pops = stale_n;
        if (!link_alive) begin
            x.err   = 2;
            x.polls = MaxResync + 1;
            x.dbs   = MaxResync;
        end else begin
            for (int i = 0; i < MaxPolls; i++) begin
                logic [7:0] b;
                bit         same;
                b      = resp_byte(i);
                same   = (((b ^ e) & m) == 8'h00);
                x.last = b;
                x.polls = i + 1;
                if (same != md) begin
                    x.pass = 1'b1;
                    break;
                end
                if (i == MaxPolls - 1) x.err = 1;
            end
            x.pops = stale_n + x.polls;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                x = exp_q.pop_front();
                chk("pass", int'(pass), int'(x.pass));
                chk("err_code", int'(err_code), x.err);
                chk("last_value", int'(last_value), int'(x.last));
                chk("poll_count", int'(poll_count), x.polls);
                chk("tx_starts", tx_count - x.tx_base, x.polls);
                chk("double_breaks", db_count - x.db_base, x.dbs);
                chk("fifo_pops", pop_count - x.pop_base, x.pops);
                chk("instr_cs_addr", int'(instr_cs_addr), int'(x.addr));
                chk("busy_at_done", int'(busy), 0);
                for (int k = x.tx_base + 1; k < tx_count; k++) begin
                    chk("tx_gap_gt_poll_gap", int'((tx_cycles[k] - tx_cycles[k-1]) > GapClks), 1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_resp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int len);
        resp_arr[0] = b0; resp_arr[1] = b1; resp_arr[2] = b2; resp_len = len;
    endtask

    task automatic run_req(input logic [3:0] a, input logic [7:0] m, input logic [7:0] e,
                           input logic md, input int stale_n);
        exp_t x;
        bit   got;
        x = predict(m, e, md, stale_n);
        x.addr = a; x.tx_base = tx_count; x.db_base = db_count; x.pop_base = pop_count;
        exp_q.push_back(x);
        @(negedge clk);
        cs_addr = a; mask = m; expect_val = e; mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        // a start while busy must not disturb the request
        cs_addr = ~a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            void'(exp_q.pop_back());
        end else begin
            @(negedge clk);
            chk("pass_held", int'(pass), int'(x.pass));
            chk("done_one_cycle", int'(done), 0);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_strobes"}, int'({done, busy, instr_converter_en, interface_tx_start,
                                      interface_rx_start, rx_fifo_rd_en, double_break_start}), 0);
        chk({name, "_poll_count"}, int'(poll_count), 0);
        chk({name, "_status"}, int'({pass, err_code, last_value, instr_cs_addr}), 0);
    endtask

    // Start a dead-link request, wait for the chosen strobe, then reset mid-cycle.
    task automatic reset_during(input bit in_resync, input string name);
        bit seen;
        link_alive = 1'b0;
        @(negedge clk);
        cs_addr = 4'h3; mask = 8'hFF; expect_val = 8'h00; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (in_resync ? double_break_start : interface_tx_start) seen = 1'b1;
        end
        if (!seen) chk({name, "_reach"}, 0, 1);
        if (!in_resync) repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_quiet(name);
        @(negedge clk);
        rst_n = 1'b1;
        link_alive = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        chk_quiet("reset");
        chk("instruction", int'(instruction), int'(UPDI_LDCS));
        chk("rx_n_bytes", int'(interface_rx_n_bytes), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // immediate pass
        set_resp(8'h30, 8'h30, 8'h30, 1);
        run_req(UPDI_CS_STATUSA, 8'hFF, 8'h00, 1'b1, 0);
        // retry twice then pass
        set_resp(8'h08, 8'h08, 8'h00, 3);
        run_req(UPDI_CS_ASI_SYS_STATUS, 8'h08, 8'h00, 1'b0, 0);
        // exhaust
        set_resp(8'h08, 8'h08, 8'h08, 1);
        run_req(UPDI_CS_ASI_SYS_STATUS, 8'h08, 8'h00, 1'b0, 0);
        // link loss
        link_alive = 1'b0;
        run_req(UPDI_CS_STATUSA, 8'h01, 8'h01, 1'b0, 0);
        link_alive = 1'b1;
        // stale bytes would pass; the fresh first byte fails
        for (int i = 0; i < 3; i++) stale_bytes[stale_total + i] = 8'h00;
        stale_total += 3;
        repeat (6) @(negedge clk);
        set_resp(8'h08, 8'h00, 8'h00, 2);
        run_req(UPDI_CS_ASI_SYS_STATUS, 8'h08, 8'h00, 1'b0, 3);

        reset_during(1'b0, "rst_wait_rx");
        set_resp(8'h5A, 8'h5A, 8'h5A, 1);
        run_req(4'h2, 8'hF0, 8'h50, 1'b0, 0);
        reset_during(1'b1, "rst_resync");
        set_resp(8'h11, 8'h22, 8'h22, 2);
        run_req(4'h7, 8'hFF, 8'h22, 1'b0, 0);

        for (int t = 0; t < 12; t++) begin
            logic [7:0] m, e;
            logic       md;
            int         n;
            m  = 8'($urandom);
            e  = 8'($urandom);
            md = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                logic [7:0] r;
                r = 8'($urandom);
                resp_arr[i] = ($urandom_range(0, 2) == 0) ? ((e & m) | (r & ~m)) : r;
            end
            resp_len = n;
            run_req(4'($urandom), m, e, md, 0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
